// File: rtl/go_arbiter.sv
// go_arbiter: round-robin arbiter that hands a single go-driven activity
// unit to one of N_REQ requesters for a bounded run of cycles.
//
// Handshake: req[i] is a level-sensitive request that requester i holds for
// as long as it wants the unit. grant[i] is the acknowledge: once it is seen
// high, the unit runs for max(len,1) cycles while req[i] stays high. Dropping
// req[i] releases the unit early. done[i] pulses for one cycle only when the
// full run length was served. Every run is followed by one COOL cycle and at
// least one IDLE cycle before the next grant.
module go_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] len,
    output logic [N_REQ-1:0] grant,
    output logic             go,
    output logic             state,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COOL   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] w_done_nxt;
    logic             r_go;
    logic             w_go_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_ptr_after;

    // Round-robin search: first set request at or above r_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Pointer value the next arbitration starts from once the owner leaves.
    always_comb begin
        if (r_owner == IDX_W'(N_REQ - 1)) begin
            w_ptr_after = '0;
        end else begin
            w_ptr_after = r_owner + 1'b1;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_go_nxt    = r_go;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                w_go_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_state_nxt = ACTIVE;
                    w_owner_nxt = w_winner;
                    // A zero length still gives the owner one go cycle.
                    w_cnt_nxt   = (len == '0) ? CNT_W'(1) : len;
                    w_grant_nxt = N_REQ'(1) << w_winner;
                    w_go_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ACTIVE: begin
                if (!req[r_owner] || (r_cnt <= CNT_W'(1))) begin
                    // Early release wins over completion on the same edge.
                    w_state_nxt = COOL;
                    w_ptr_nxt   = w_ptr_after;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = '0;
                    w_go_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    if (req[r_owner]) begin
                        w_done_nxt = N_REQ'(1) << r_owner;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            COOL: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_go_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_go_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_go    <= w_go_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign grant       = r_grant;
    assign go          = r_go;
    assign state       = r_go;
    assign done        = r_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_go_arbiter.sv
// tb_go_arbiter: randomized and directed runs of go_arbiter checked by a
// run-level scoreboard fed from a behavioural model of the arbitration rules.
module tb_go_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int EW = 2 * N + 24;   // {grant, go length(16), done, gap(8)}

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [CW-1:0] len;
    logic [N-1:0]  grant;
    logic          go;
    logic          state;
    logic [N-1:0]  done;
    logic          busy;
    logic [1:0]    dbg_state;

    go_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .len        (len),
        .grant      (grant),
        .go         (go),
        .state      (state),
        .done       (done),
        .busy       (busy),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    int            m_ptr   = 0;   // model round-robin pointer
    int            d_gap   = 0;   // expected go-low cycles before next run

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: first requester at or after p, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int win, input int golen, input logic [N-1:0] dn);
        exp_q.push_back({onehot(win), 16'(golen), dn, 8'(d_gap)});
        d_gap = 2;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT is idle with req low.
    task automatic run_txn(input logic [N-1:0] vec, input int ln, input int rel);
        int lf;
        int win;
        int golen;
        logic [N-1:0] oh;
        logic [N-1:0] dn;
        lf  = (ln == 0) ? 1 : ln;
        win = pick(vec, m_ptr);
        oh  = onehot(win);
        if (rel != 0 && rel <= lf) begin
            golen = rel;
            dn    = '0;
        end else begin
            golen = lf;
            dn    = oh;
        end
        m_ptr = (win + 1) % N;
        push_exp(win, golen, dn);
        req = vec;
        len = CW'(ln);
        for (int j = 1; j <= golen; j++) begin
            @(negedge clk);
            len = CW'($urandom);
            if (j == rel) req = N'($urandom) & ~oh;
            else          req = oh | (N'($urandom) & ~oh);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req   = '0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        d_gap = 0;
    endtask

    task automatic held_rr();
        int win;
        for (int r = 0; r < 5; r++) begin
            win   = pick(4'b1111, m_ptr);
            push_exp(win, 1, onehot(win));
            m_ptr = (win + 1) % N;
        end
        req = 4'b1111;
        len = 8'd1;
        repeat (14) @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic reset_mid_run(input logic [N-1:0] vec);
        int win;
        win = pick(vec, m_ptr);
        push_exp(win, 2, '0);
        req = vec;
        len = 8'd5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        m_ptr = 0;
        d_gap = 0;
    endtask

    // ---------------- monitor ----------------
    logic          m_prev_go   = 1'b0;
    int            m_gap       = 0;
    int            m_len       = 0;
    logic [N-1:0]  m_cur_grant = '0;
    logic [EW-1:0] m_e;

    task automatic end_run();
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_end: got run of %0d cycles expected no run", m_len);
        end else begin
            m_e = exp_q.pop_front();
            chk("run_len", m_len, 32'(m_e[N+23 -: 16]));
            chk("run_done", done, 32'(m_e[8 +: N]));
        end
    endtask

    // Samples outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        chk("state_eq_go", state, go);
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        if (!rst_n) begin
            chk("rst_grant", grant, 0);
            chk("rst_go", go, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dbg", dbg_state, 0);
            if (m_prev_go) end_run();
            m_prev_go = 1'b0;
            m_gap     = 0;
        end else begin
            if (go && !m_prev_go) begin
                m_cur_grant = grant;
                m_len       = 1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL run_start: got grant %0h expected no run", grant);
                end else begin
                    chk("run_grant", grant, 32'(exp_q[0][EW-1 -: N]));
                    chk("run_gap", m_gap, 32'(exp_q[0][7:0]));
                end
                chk("busy_active", busy, 1);
                chk("done_active", done, 0);
            end else if (go) begin
                m_len++;
                chk("grant_hold", grant, m_cur_grant);
                chk("busy_active", busy, 1);
                chk("done_active", done, 0);
            end else if (m_prev_go) begin
                end_run();
                chk("busy_cool", busy, 1);
                chk("grant_cool", grant, 0);
                m_gap = 1;
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, 0);
                chk("grant_idle", grant, 0);
                m_gap++;
            end
            m_prev_go = go;
        end
    end

    // ---------------- stimulus and report ----------------
    initial begin
        logic [N-1:0] v;
        int ln;
        int rel;
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        d_gap = 0;

        run_txn(4'b0100, 3, 0);         // single run, len 3
        do_reset(2);
        held_rr();                      // held 1111, len 1, rotation
        run_txn(4'b0001, 0, 0);         // zero length
        run_txn(4'b0010, 10, 4);        // early release in 4th cycle
        run_txn(4'b0101, 2, 0);         // resumes from pointer 2
        run_txn(4'b1000, 3, 3);         // release on the completion edge
        reset_mid_run(4'b0100);
        run_txn(4'b1001, 2, 0);         // first arbitration after reset
        run_txn(N'($urandom_range(1, 15)), 255, 0);
        run_txn(N'($urandom_range(1, 15)), 1, 0);

        for (int t = 0; t < 40; t++) begin
            v   = N'($urandom_range(1, 15));
            ln  = $urandom_range(0, 12);
            rel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            run_txn(v, ln, rel);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/go_arbiter.md
GO_ARBITER -- requirements
Module: go_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single go-driven activity unit.
REQ-002 Parameter CNT_W, default 8: width of the run-length field and internal run counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req  input  N_REQ  per-requester request, level-sensitive; bit i = requester i wants the unit.
REQ-006 len  input  CNT_W  run length in cycles, sampled only on the grant cycle.
REQ-007 grant  output  N_REQ  one-hot current owner, or all-zero when no owner.
REQ-008 go  output  1  drive to the activity unit; high exactly while in ACTIVE.
REQ-009 state  output  1  0 = unit IDLE, 1 = unit ACTIVE; always equals go.
REQ-010 done  output  N_REQ  one-cycle pulse on bit i when requester i's run completes its full length.
REQ-011 busy  output  1  high in ACTIVE and COOL, low in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACTIVE and COOL; all outputs SHALL be registered.
REQ-013 IDLE, no req bit set: the FSM SHALL remain in IDLE with go=0, grant=0, done=0.
REQ-014 IDLE, any req bit set at edge t: the FSM SHALL enter ACTIVE at edge t, so grant, go and state are high from cycle t+1 (one-cycle latency).
REQ-015 Selection SHALL be round-robin: winner = first set req bit at or above pointer ptr, wrapping from N_REQ-1 to 0.
REQ-016 On the grant edge, the run counter SHALL load len; len=0 SHALL be treated as 1.
REQ-017 In ACTIVE, the counter SHALL decrement by 1 per cycle, so go stays high for exactly max(len,1) cycles.
REQ-018 In ACTIVE with counter==1 and req[owner] still high, the FSM SHALL move to COOL and pulse done[owner] in the first COOL cycle.
REQ-019 Early release: if req[owner] is low in any ACTIVE cycle, the FSM SHALL move to COOL at that edge with no done pulse.
REQ-020 Early release SHALL take priority over normal completion when both occur on the same edge.
REQ-021 On entry to COOL, ptr SHALL become (owner+1) mod N_REQ.
REQ-022 COOL SHALL last exactly one cycle with go=0, grant=0, busy=1.
REQ-023 COOL SHALL always transition to IDLE, so back-to-back runs are separated by at least 2 go-low cycles (COOL plus IDLE).
REQ-024 Request changes from non-owners during ACTIVE or COOL SHALL have no effect on the current run.
REQ-025 The counter SHALL never wrap below 0.
REQ-026 grant SHALL be zero or one-hot at all times.
REQ-027 done SHALL be zero or one-hot and high for at most one cycle per run.

Reset
REQ-028 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE with ptr=0, counter=0, grant=0, go=0, state=0, done=0 and busy=0.
REQ-029 Reset asserted mid-ACTIVE SHALL abort the run with no done pulse; go SHALL be low from the cycle after the reset edge.
REQ-030 After reset release, the first arbitration SHALL start from requester 0.

Verification
REQ-031 Single run: after reset, req=4'b0100 and len=3 -> grant=4'b0100 and go=1 for cycles 1-3, done=4'b0100 in cycle 4, IDLE in cycle 5.
REQ-032 Round-robin: req=4'b1111 held and len=1 -> grants in order 0001, 0010, 0100, 1000, 0001, with 2 go-low cycles between runs.
REQ-033 Zero length: req=4'b0001 and len=0 -> go high for exactly 1 cycle, then done=4'b0001.
REQ-034 Early release: req=4'b0010, len=10, req dropped in the 4th ACTIVE cycle -> go falls after 4 cycles, done never pulses, next ptr=2.
REQ-035 Reset mid-run: len=5, rst_n=0 in the 2nd ACTIVE cycle -> all outputs 0 from the next cycle; with req=4'b1001 after release, grant=4'b0001.
REQ-036 Invariant checks throughout: state==go, grant one-hot or zero, done at most one cycle per run, busy==(state!=IDLE).
